// File: rtl/ofdm_frame_sequencer.sv
// rtl/ofdm_frame_sequencer.sv - gates a sample stream into triggered frames with offset and CP gaps
module ofdm_frame_sequencer #(
  parameter int              WIDTH         = 32,
  parameter int              CNT_W         = 16,
  parameter logic [7:0]      SR_FRAME_LEN  = 8'd16,
  parameter logic [7:0]      SR_GAP_LEN    = 8'd17,
  parameter logic [7:0]      SR_OFFSET     = 8'd18,
  parameter logic [7:0]      SR_NUM_FRAMES = 8'd19,
  parameter logic [7:0]      SR_CLEAR      = 8'd20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_ttrig,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tuser,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_OFFSET, S_FRAME, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] frame_sh, gap_sh, offset_sh, num_sh;
  logic [CNT_W-1:0] frame_len, gap_len, num_frames;
  logic [CNT_W-1:0] frame_len_nxt, gap_len_nxt, num_frames_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, frame_cnt_nxt;
  logic             first, first_nxt;
  logic [CNT_W-1:0] f_len, g_len, n_frm, pos, done_cnt, done_inc;
  logic             pass, latch, clear;
  logic             unused_data;

  assign clear       = set_stb && (set_addr == SR_CLEAR);
  assign unused_data = ^set_data[31:CNT_W];
  assign o_tdata     = i_tdata;
  assign busy        = (state != S_IDLE);
  assign done_inc    = done_cnt + CNT_W'(1);

  // Shadow registers; only copied into the active set on a trigger beat
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_sh  <= CNT_W'(64);
      gap_sh    <= CNT_W'(16);
      offset_sh <= '0;
      num_sh    <= CNT_W'(1);
    end else if (set_stb) begin
      case (set_addr)
        SR_FRAME_LEN:  frame_sh  <= set_data[CNT_W-1:0];
        SR_GAP_LEN:    gap_sh    <= set_data[CNT_W-1:0];
        SR_OFFSET:     offset_sh <= set_data[CNT_W-1:0];
        SR_NUM_FRAMES: num_sh    <= set_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      frame_cnt  <= '0;
      first      <= 1'b0;
      frame_len  <= CNT_W'(64);
      gap_len    <= CNT_W'(16);
      num_frames <= CNT_W'(1);
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      frame_cnt  <= frame_cnt_nxt;
      first      <= first_nxt;
      frame_len  <= frame_len_nxt;
      gap_len    <= gap_len_nxt;
      num_frames <= num_frames_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    frame_cnt_nxt  = frame_cnt;
    first_nxt      = first;
    frame_len_nxt  = frame_len;
    gap_len_nxt    = gap_len;
    num_frames_nxt = num_frames;
    f_len          = frame_len;
    g_len          = gap_len;
    n_frm          = num_frames;
    pos            = cnt;
    done_cnt       = frame_cnt;
    pass           = 1'b0;
    latch          = 1'b0;
    i_tready       = 1'b1;
    o_tvalid       = 1'b0;
    o_tlast        = 1'b0;
    o_tuser        = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_tvalid && i_ttrig) begin
          // The frame logic below runs on the about-to-be-latched values
          f_len    = (frame_sh == '0) ? CNT_W'(1) : frame_sh;
          g_len    = gap_sh;
          n_frm    = num_sh;
          pos      = '0;
          done_cnt = '0;
          if (offset_sh != '0) begin
            latch         = 1'b1;
            frame_cnt_nxt = '0;
            first_nxt     = 1'b1;
            cnt_nxt       = offset_sh - CNT_W'(1);
            state_nxt     = (offset_sh == CNT_W'(1)) ? S_FRAME : S_OFFSET;
          end else begin
            pass    = 1'b1;
            o_tuser = 1'b1;
          end
        end
      end
      S_OFFSET: begin
        if (i_tvalid) begin
          if (cnt == CNT_W'(1)) begin
            state_nxt = S_FRAME;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      S_FRAME: begin
        pass    = 1'b1;
        o_tuser = first;
      end
      S_GAP: begin
        if (i_tvalid) begin
          if (cnt == gap_len - CNT_W'(1)) begin
            state_nxt = S_FRAME;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (pass) begin
      i_tready = o_tready;
      o_tvalid = i_tvalid;
      o_tlast  = (pos == f_len - CNT_W'(1));
      if (i_tvalid && o_tready) begin
        latch     = (state == S_IDLE);
        first_nxt = 1'b0;
        if (o_tlast) begin
          frame_cnt_nxt = done_inc;
          cnt_nxt       = '0;
          if (n_frm != '0 && done_inc == n_frm) state_nxt = S_IDLE;
          else if (g_len == '0)                 state_nxt = S_FRAME;
          else                                  state_nxt = S_GAP;
        end else begin
          frame_cnt_nxt = done_cnt;
          cnt_nxt       = pos + CNT_W'(1);
          state_nxt     = S_FRAME;
        end
      end
    end

    if (latch) begin
      frame_len_nxt  = f_len;
      gap_len_nxt    = g_len;
      num_frames_nxt = n_frm;
    end

    // Abort wins over any beat in the same cycle; frame_cnt keeps its value
    if (clear) begin
      state_nxt      = S_IDLE;
      cnt_nxt        = cnt;
      frame_cnt_nxt  = frame_cnt;
      first_nxt      = first;
      frame_len_nxt  = frame_len;
      gap_len_nxt    = gap_len;
      num_frames_nxt = num_frames;
    end
  end

endmodule
